// File: rtl/rs232_tx_fifo.sv
// Parametrised RS232 transmitter with a small input FIFO and CTS flow control.
// Frames are start, DATA_W data bits LSB first, optional parity, then STOP_BITS stop bits.
module rs232_tx_fifo #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 19200,
   parameter int DATA_W     = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_ready,
   input  logic [DATA_W-1:0] data,
   input  logic              cts,
   output logic              full,
   output logic              overflow,
   output logic              tx,
   output logic              rts,
   output logic              busy
);

   localparam int DIV    = CLK_HZ / BAUD;
   localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W  = $clog2(DATA_W);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FILL_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [FILL_W-1:0] count;
   logic [FILL_W-1:0] count_next;

   state_t            state;
   logic [CNT_W-1:0]  baud_cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-1:0] shreg;
   logic              parity_bit;

   logic              bit_end;
   logic              stop_done;
   logic              push;
   logic              pop;
   logic              busy_next;
   logic [DATA_W-1:0] head;
   logic              head_parity;

   // A pop happens only at the decision points (IDLE or the final stop-bit cycle),
   // so busy and rts can be registered from their next-cycle values.
   always_comb begin
      bit_end     = (baud_cnt == CNT_W'(DIV - 1));
      stop_done   = (state == S_STOP) && bit_end && (bit_idx == IDX_W'(STOP_BITS - 1));
      pop         = ((state == S_IDLE) || stop_done) && (count != '0) && cts;
      push        = data_ready && !full;
      count_next  = count + FILL_W'(push) - FILL_W'(pop);
      busy_next   = pop || ((state != S_IDLE) && !stop_done);
      head        = mem[rd_ptr];
      head_parity = (PARITY == 1) ? ~^head : ^head;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= data;
   end

   // FIFO bookkeeping; a write while full is dropped even if a pop frees a slot on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         overflow <= 1'b0;
         rts      <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count    <= count_next;
         full     <= (count_next == FILL_W'(FIFO_DEPTH));
         overflow <= data_ready && full;
         rts      <= (count_next != '0) || busy_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tx         <= 1'b1;
         busy       <= 1'b0;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         parity_bit <= 1'b0;
      end else begin
         busy     <= busy_next;
         baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
         case (state)
            S_IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (pop) begin
                  state      <= S_START;
                  tx         <= 1'b0;
                  shreg      <= head;
                  parity_bit <= head_parity;
               end
            end
            S_START: begin
               if (bit_end) begin
                  state <= S_DATA;
                  tx    <= shreg[0];
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (bit_idx == IDX_W'(DATA_W - 1)) begin
                     bit_idx <= '0;
                     if (PARITY != 0) begin
                        state <= S_PAR;
                        tx    <= parity_bit;
                     end else begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end
            end
            S_PAR: begin
               if (bit_end) begin
                  state <= S_STOP;
                  tx    <= 1'b1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  if (stop_done) begin
                     bit_idx <= '0;
                     if (pop) begin
                        state      <= S_START;
                        tx         <= 1'b0;
                        shreg      <= head;
                        parity_bit <= head_parity;
                     end else begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Directed bench for rs232_tx_fifo: four configurations (8N1, 8E1, 8O1, 7N2) at DIV=10,
// a table of single-frame vectors plus hand-written flow-control and reset sequences.
module tb_rs232_tx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] dr_s;
   logic [3:0] cts_s;
   logic [7:0] din_s [4];
   wire  [3:0] full_s;
   wire  [3:0] ovf_s;
   wire  [3:0] tx_s;
   wire  [3:0] rts_s;
   wire  [3:0] busy_s;

   int vec_count  = 0;
   int miss_count = 0;

   logic tx_hist   [512];
   logic busy_hist [512];
   logic rts_hist  [512];
   logic full_hist [512];

   typedef struct {
      int          unit;
      logic [7:0]  word;
      int          nbits;
      logic [11:0] frame;
      int          busy_len;
      string       name;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   rs232_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .clk(clk), .rst(rst), .data_ready(dr_s[0]), .data(din_s[0]), .cts(cts_s[0]),
      .full(full_s[0]), .overflow(ovf_s[0]), .tx(tx_s[0]), .rts(rts_s[0]), .busy(busy_s[0]));

   rs232_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
      .clk(clk), .rst(rst), .data_ready(dr_s[1]), .data(din_s[1]), .cts(cts_s[1]),
      .full(full_s[1]), .overflow(ovf_s[1]), .tx(tx_s[1]), .rts(rts_s[1]), .busy(busy_s[1]));

   rs232_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
      .clk(clk), .rst(rst), .data_ready(dr_s[2]), .data(din_s[2]), .cts(cts_s[2]),
      .full(full_s[2]), .overflow(ovf_s[2]), .tx(tx_s[2]), .rts(rts_s[2]), .busy(busy_s[2]));

   rs232_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_W(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
      .clk(clk), .rst(rst), .data_ready(dr_s[3]), .data(din_s[3][6:0]), .cts(cts_s[3]),
      .full(full_s[3]), .overflow(ovf_s[3]), .tx(tx_s[3]), .rts(rts_s[3]), .busy(busy_s[3]));

   function automatic vec_t mk(input int u, input logic [7:0] w, input int nb,
                               input logic [11:0] f, input int bl, input string nm);
      vec_t v;
      v.unit = u; v.word = w; v.nbits = nb; v.frame = f; v.busy_len = bl; v.name = nm;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      vec_count++;
      if (actual != expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One write strobe; returns at the falling edge after the write edge.
   task automatic applyStimulus(input int u, input logic [7:0] w);
      @(negedge clk);
      dr_s[u]  = 1'b1;
      din_s[u] = w;
      @(negedge clk);
      dr_s[u]  = 1'b0;
   endtask

   task automatic runRecord(input int u, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         tx_hist[c]   = tx_s[u];
         busy_hist[c] = busy_s[u];
         rts_hist[c]  = rts_s[u];
         full_hist[c] = full_s[u];
      end
   endtask

   function automatic int histOnes(input int which, input int a, input int b);
      int n = 0;
      for (int c = a; c <= b; c++) begin
         case (which)
            0:       n += int'(tx_hist[c]);
            1:       n += int'(busy_hist[c]);
            2:       n += int'(rts_hist[c]);
            default: n += int'(full_hist[c]);
         endcase
      end
      return n;
   endfunction

   function automatic logic [11:0] midBits(input int c0, input int nb);
      logic [11:0] r = '0;
      for (int i = 0; i < nb; i++)
         r[i] = tx_hist[c0 + 10*i + 5];
      return r;
   endfunction

   initial begin
      logic [7:0]  words [5];
      logic [5:0]  tail;
      logic [11:0] f;
      int          good;

      rst   = 1'b1;
      dr_s  = '0;
      cts_s = '1;
      for (int u = 0; u < 4; u++) din_s[u] = '0;

      vecs[0] = mk(0, 8'h6A, 10, {2'b00, 1'b1, 8'h6A, 1'b0}, 100, "8n1_6a");
      vecs[1] = mk(0, 8'h00, 10, {2'b00, 1'b1, 8'h00, 1'b0}, 100, "8n1_00");
      vecs[2] = mk(0, 8'hFF, 10, {2'b00, 1'b1, 8'hFF, 1'b0}, 100, "8n1_ff");
      vecs[3] = mk(1, 8'hCC, 11, {1'b0, 1'b1, 1'b0, 8'hCC, 1'b0}, 110, "8e1_cc");
      vecs[4] = mk(1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 110, "8e1_07");
      vecs[5] = mk(2, 8'hCC, 11, {1'b0, 1'b1, 1'b1, 8'hCC, 1'b0}, 110, "8o1_cc");
      vecs[6] = mk(2, 8'h07, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 110, "8o1_07");
      vecs[7] = mk(3, 8'h55, 10, {2'b00, 2'b11, 7'h55, 1'b0}, 100, "7n2_55");

      repeat (3) @(negedge clk);
      for (int u = 0; u < 4; u++)
         checkOutput($sformatf("reset_u%0d", u),
                     int'({tx_s[u], busy_s[u], rts_s[u], full_s[u], ovf_s[u]}), 5'b10000);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single frames: every sample of every bit, busy length and rts release.
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].unit, vecs[v].word);
         runRecord(vecs[v].unit, vecs[v].nbits*10 + 20);
         for (int k = 0; k < vecs[v].nbits; k++) begin
            good = 0;
            for (int s = 0; s < 10; s++)
               if (tx_hist[10*k + s] == vecs[v].frame[k]) good++;
            checkOutput($sformatf("%s_bit%0d_samples", vecs[v].name, k), good, 10);
         end
         checkOutput({vecs[v].name, "_busy_len"}, histOnes(1, 0, vecs[v].nbits*10 + 19),
                     vecs[v].busy_len);
         checkOutput({vecs[v].name, "_rts_during"}, int'(rts_hist[0]), 1);
         checkOutput({vecs[v].name, "_rts_after"}, int'(rts_hist[vecs[v].busy_len]), 0);
         checkOutput({vecs[v].name, "_idle_tail"},
                     histOnes(0, vecs[v].busy_len, vecs[v].nbits*10 + 19), 20);
      end

      // Fill with cts low, overflow on the fifth write, then four back-to-back frames.
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
      cts_s[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 3) checkOutput("fill_full_after3", int'(full_s[0]), 0);
         if (k == 4) checkOutput("fill_full_after4", int'(full_s[0]), 1);
         dr_s[0]  = 1'b1;
         din_s[0] = words[k];
      end
      @(negedge clk);
      dr_s[0] = 1'b0;
      checkOutput("fill_overflow", int'(ovf_s[0]), 1);
      checkOutput("fill_rts", int'(rts_s[0]), 1);
      checkOutput("fill_tx_idle", int'(tx_s[0]), 1);
      @(negedge clk);
      checkOutput("fill_overflow_pulse", int'(ovf_s[0]), 0);
      runRecord(0, 20);
      checkOutput("fill_hold_tx", histOnes(0, 0, 19), 20);
      checkOutput("fill_hold_busy", histOnes(1, 0, 19), 0);
      cts_s[0] = 1'b1;
      runRecord(0, 420);
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("b2b_frame%0d", k), int'(midBits(100*k, 10)),
                     int'({2'b00, 1'b1, words[k], 1'b0}));
      checkOutput("b2b_busy_len", histOnes(1, 0, 419), 400);
      checkOutput("b2b_busy_contig", histOnes(1, 0, 399), 400);
      checkOutput("b2b_full_released", int'(full_hist[0]), 0);
      checkOutput("b2b_rts_after", int'(rts_hist[400]), 0);
      checkOutput("b2b_tail_idle", histOnes(0, 400, 419), 20);

      // cts drops mid-frame with two words queued: frame completes, then hold.
      @(negedge clk);
      dr_s[0] = 1'b1; din_s[0] = 8'hA5;
      @(negedge clk);
      din_s[0] = 8'h3C;
      @(negedge clk);
      din_s[0] = 8'hC3;
      @(negedge clk);
      dr_s[0] = 1'b0;
      repeat (30) @(negedge clk);
      cts_s[0] = 1'b0;
      runRecord(0, 150);
      tail = '0;
      for (int i = 4; i < 10; i++) tail[i-4] = tx_hist[10*i + 5 - 32];
      checkOutput("cts_drop_frame_tail", int'(tail), 6'b110100);
      checkOutput("cts_drop_busy_len", histOnes(1, 0, 149), 68);
      checkOutput("cts_drop_tx_hold", histOnes(0, 68, 149), 82);
      checkOutput("cts_drop_rts_held", int'(rts_hist[149]), 1);
      cts_s[0] = 1'b1;
      runRecord(0, 220);
      f = {2'b00, 1'b1, 8'h3C, 1'b0};
      checkOutput("cts_resume_frame0", int'(midBits(0, 10)), int'(f));
      f = {2'b00, 1'b1, 8'hC3, 1'b0};
      checkOutput("cts_resume_frame1", int'(midBits(100, 10)), int'(f));
      checkOutput("cts_resume_busy_len", histOnes(1, 0, 219), 200);
      checkOutput("cts_resume_rts_after", int'(rts_hist[200]), 0);

      // Reset during data bit 3 of the first frame with more words queued.
      @(negedge clk);
      dr_s[0] = 1'b1; din_s[0] = 8'hF7;
      @(negedge clk);
      din_s[0] = 8'h12;
      @(negedge clk);
      din_s[0] = 8'h34;
      @(negedge clk);
      dr_s[0] = 1'b0;
      repeat (44) @(negedge clk);
      checkOutput("rst_pre_bit3", int'(tx_s[0]), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_tx", int'(tx_s[0]), 1);
      checkOutput("rst_busy", int'(busy_s[0]), 0);
      checkOutput("rst_rts", int'(rts_s[0]), 0);
      checkOutput("rst_full", int'(full_s[0]), 0);
      runRecord(0, 250);
      checkOutput("rst_no_frames_tx", histOnes(0, 0, 249), 250);
      checkOutput("rst_no_frames_busy", histOnes(1, 0, 249), 0);
      checkOutput("rst_no_frames_rts", histOnes(2, 0, 249), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
